lr_consistency_check: RTL

//   Left-right consistency check feeding hole_filling. Consumes co-timed left/right disparity streams
//   (raster order, one pixel pair per accepted beat) and emits {mismatch, occlusion, disp}, the

---
 rtl/lr_consistency_check.sv | 137 +++++++++++++
 1 files changed

// File: rtl/lr_consistency_check.sv
// Left-right disparity consistency check.
// Buffers right-view disparities by column and classifies each left pixel
// against the right pixel it maps onto, producing {mismatch, occlusion, disp}.
module lr_consistency_check #(
  parameter int unsigned DWIDTH = 7,
  parameter int unsigned THRESH = 1,
  parameter int unsigned DEPTH  = 2**DWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clken,
  input  logic [10:0]       width,
  input  logic              enable,
  input  logic [DWIDTH-1:0] disp_L,
  input  logic [DWIDTH-1:0] disp_R,
  output logic [DWIDTH+1:0] dout,
  output logic              valid,
  output logic              eol
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Column counter and right-disparity buffer
  logic [10:0]       r_col;
  logic [DWIDTH-1:0] r_buf [DEPTH];

  // Stage 1 registers
  logic [DWIDTH-1:0] r_dl_s1;
  logic [10:0]       r_col_s1;
  logic              r_eol_s1;
  logic              r_v1;

  // Stage 2 (output) registers
  logic [DWIDTH+1:0] r_dout;
  logic              r_valid;
  logic              r_eol;

  logic              w_accept;
  logic [10:0]       w_last;
  logic              w_row_end;
  logic [AW-1:0]     w_wr_addr;
  logic [11:0]       w_idx;
  logic              w_idx_neg;
  logic [AW-1:0]     w_rd_addr;
  logic [DWIDTH-1:0] w_dr;
  logic [DWIDTH:0]   w_dl_x;
  logic [DWIDTH:0]   w_dr_x;
  logic [DWIDTH:0]   w_diff;
  logic [DWIDTH:0]   w_thr;
  logic              w_occ;
  logic              w_mis;

  assign w_accept  = clken & enable;
  assign w_last    = width - 11'd1;
  assign w_row_end = (r_col == w_last);
  assign w_wr_addr = AW'(32'(r_col) % DEPTH);

  // idx is negative when the left pixel maps left of column 0 of this row;
  // such entries are flagged as occlusion before the buffer is consulted.
  assign w_idx     = {1'b0, r_col_s1} - 12'(r_dl_s1);
  assign w_idx_neg = w_idx[11];
  assign w_rd_addr = AW'(32'(w_idx[10:0]) % DEPTH);
  assign w_dr      = r_buf[w_rd_addr];

  assign w_dl_x = {1'b0, r_dl_s1};
  assign w_dr_x = {1'b0, w_dr};
  assign w_thr  = (DWIDTH+1)'(THRESH);

  // Classify the stage-1 pixel: occlusion has priority, then consistency, then mismatch
  always_comb begin
    w_diff = (w_dl_x >= w_dr_x) ? (w_dl_x - w_dr_x) : (w_dr_x - w_dl_x);
    w_occ  = 1'b0;
    w_mis  = 1'b0;
    if (w_idx_neg) begin
      w_occ = 1'b1;
    end else if (w_diff <= w_thr) begin
      w_occ = 1'b0;
    end else if (w_dr_x > (w_dl_x + w_thr)) begin
      w_occ = 1'b1;
    end else begin
      w_mis = 1'b1;
    end
  end

  // Store right disparity for the current column on every accepted beat
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf[w_wr_addr] <= disp_R;
    end
  end

  // Column counter with wrap at the configured row width
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '0;
    end else if (w_accept) begin
      r_col <= w_row_end ? '0 : r_col + 11'd1;
    end
  end

  // Stage 1: capture left disparity and column position of the accepted beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dl_s1  <= '0;
      r_col_s1 <= '0;
      r_eol_s1 <= 1'b0;
      r_v1     <= 1'b0;
    end else if (clken) begin
      r_v1 <= enable;
      if (enable) begin
        r_dl_s1  <= disp_L;
        r_col_s1 <= r_col;
        r_eol_s1 <= w_row_end;
      end
    end
  end

  // Stage 2: register classified output; data holds through enable gaps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_eol   <= 1'b0;
    end else if (clken) begin
      r_valid <= r_v1;
      r_eol   <= r_v1 & r_eol_s1;
      if (r_v1) begin
        r_dout <= {w_mis, w_occ, r_dl_s1};
      end
    end
  end

  assign dout  = r_dout;
  assign valid = r_valid;
  assign eol   = r_eol;

endmodule
